// File: rtl/data_stack_cached.sv
// Operand stack with TOS/NOS held in registers and deeper entries spilled to a
// synchronous-read RAM; one-cycle REFILL reloads NOS after POP/REDUCE.
module data_stack_cached #(
    parameter int  DATA_WIDTH = 8,
    parameter int  DEPTH      = 16,
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_code,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] tos,
    output logic [DATA_WIDTH-1:0] nos,
    output logic [CNT_WIDTH-1:0]  depth,
    output logic                  empty,
    output logic                  full,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int RAM_WORDS = DEPTH - 2;
    localparam int AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_DUP     = 3'b011;
    localparam logic [2:0] OP_SWAP    = 3'b100;
    localparam logic [2:0] OP_REDUCE  = 3'b101;
    localparam logic [2:0] OP_REPLACE = 3'b110;
    localparam logic [2:0] OP_CLEAR   = 3'b111;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TWO  = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] CNT_SIX3 = CNT_WIDTH'(3);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_REFILL
    } state_t;

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   tos_reg, tos_next;
    logic [DATA_WIDTH-1:0]   nos_reg, nos_next;
    logic [CNT_WIDTH-1:0]    depth_reg, depth_next;
    logic                    ovf_reg, ovf_next;
    logic                    unf_reg, unf_next;

    logic                    accept;
    logic                    at_full;
    logic                    has_one;
    logic                    has_two;
    logic                    has_three;

    logic                    ram_we;
    logic [AW-1:0]           ram_waddr;
    logic                    ram_re;
    logic [AW-1:0]           ram_raddr;
    logic [DATA_WIDTH-1:0]   ram_mem [RAM_WORDS];
    logic [DATA_WIDTH-1:0]   ram_rdata_reg;

    assign op_ready  = (state_reg == ST_IDLE);
    assign accept    = op_valid && op_ready;
    assign at_full   = (depth_reg == CNT_MAX);
    assign has_one   = (depth_reg != '0);
    assign has_two   = (depth_reg >= CNT_TWO);
    assign has_three = (depth_reg >= CNT_SIX3);

    // Entry at depth position k lives at RAM index k-3, so a spill of NOS
    // (becoming position n+1) lands at n-2 and a refill reads n-3.
    assign ram_waddr = AW'(depth_reg - CNT_TWO);
    assign ram_raddr = AW'(depth_reg - CNT_SIX3);

    always_comb begin
        state_next = state_reg;
        tos_next   = tos_reg;
        nos_next   = nos_reg;
        depth_next = depth_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    case (op_code)
                        OP_NOP: ;
                        OP_PUSH: begin
                            if (at_full) begin
                                ovf_next = 1'b1;
                            end else begin
                                ram_we     = has_two;
                                nos_next   = tos_reg;
                                tos_next   = din;
                                depth_next = depth_reg + CNT_ONE;
                            end
                        end
                        OP_DUP: begin
                            if (at_full) begin
                                ovf_next = 1'b1;
                            end else if (!has_one) begin
                                unf_next = 1'b1;
                            end else begin
                                ram_we     = has_two;
                                nos_next   = tos_reg;
                                depth_next = depth_reg + CNT_ONE;
                            end
                        end
                        OP_POP: begin
                            if (!has_one) begin
                                unf_next = 1'b1;
                            end else begin
                                tos_next   = nos_reg;
                                depth_next = depth_reg - CNT_ONE;
                                if (has_three) begin
                                    ram_re     = 1'b1;
                                    state_next = ST_REFILL;
                                end else begin
                                    nos_next = '0;
                                end
                            end
                        end
                        OP_SWAP: begin
                            if (!has_two) begin
                                unf_next = 1'b1;
                            end else begin
                                tos_next = nos_reg;
                                nos_next = tos_reg;
                            end
                        end
                        OP_REDUCE: begin
                            if (!has_two) begin
                                unf_next = 1'b1;
                            end else begin
                                tos_next   = din;
                                depth_next = depth_reg - CNT_ONE;
                                if (has_three) begin
                                    ram_re     = 1'b1;
                                    state_next = ST_REFILL;
                                end else begin
                                    nos_next = '0;
                                end
                            end
                        end
                        OP_REPLACE: begin
                            if (!has_one) begin
                                unf_next = 1'b1;
                            end else begin
                                tos_next = din;
                            end
                        end
                        OP_CLEAR: begin
                            tos_next   = '0;
                            nos_next   = '0;
                            depth_next = '0;
                            ovf_next   = 1'b0;
                            unf_next   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_REFILL: begin
                nos_next   = ram_rdata_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            tos_reg   <= '0;
            nos_reg   <= '0;
            depth_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            tos_reg   <= tos_next;
            nos_reg   <= nos_next;
            depth_reg <= depth_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    // Spill RAM carries no reset so it maps onto block RAM; the write is
    // suppressed while reset is held so an aborted op leaves nothing behind.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            ram_mem[ram_waddr] <= nos_reg;
        end
        if (ram_re) begin
            ram_rdata_reg <= ram_mem[ram_raddr];
        end
    end

    assign tos           = tos_reg;
    assign nos           = nos_reg;
    assign depth         = depth_reg;
    assign empty         = (depth_reg == '0);
    assign full          = at_full;
    assign err_overflow  = ovf_reg;
    assign err_underflow = unf_reg;

endmodule

// File: tb/tb_data_stack_cached.sv
// Directed bench for data_stack_cached: a queue-based stack model is checked
// against the DUT every cycle, with hand-computed literals pinning key points.
module tb_data_stack_cached;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3;
    localparam logic [2:0] SWAP = 3'd4, REDUCE = 3'd5, REPLACE = 3'd6, CLEAR = 3'd7;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_code;
    logic [DW-1:0] din;
    logic [DW-1:0] tos;
    logic [DW-1:0] nos;
    logic [CW-1:0] depth;
    logic          empty;
    logic          full;
    logic          err_overflow;
    logic          err_underflow;

    data_stack_cached #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_code       (op_code),
        .din           (din),
        .tos           (tos),
        .nos           (nos),
        .depth         (depth),
        .empty         (empty),
        .full          (full),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: stk[$] is the top of stack.
    logic [DW-1:0] stk[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic          exp_ready = 1'b1;
    logic          chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_tos();
        return (stk.size() > 0) ? stk[stk.size()-1] : '0;
    endfunction

    function automatic logic [DW-1:0] m_nos();
        return (stk.size() > 1) ? stk[stk.size()-2] : '0;
    endfunction

    // Applies one accepted op; returns 1 when the op leaves a spilled entry
    // to be brought into NOS (busy for one cycle).
    function automatic bit model_apply(input logic [2:0] c, input logic [DW-1:0] d);
        int n = stk.size();
        logic [DW-1:0] a, b;
        bit busy = 0;
        case (c)
            PUSH:    if (n == DEPTH) m_ovf = 1; else stk.push_back(d);
            DUP:     if (n == DEPTH) m_ovf = 1;
                     else if (n == 0) m_unf = 1;
                     else stk.push_back(stk[n-1]);
            POP:     if (n == 0) m_unf = 1;
                     else begin void'(stk.pop_back()); busy = (n >= 3); end
            SWAP:    if (n < 2) m_unf = 1;
                     else begin a = stk.pop_back(); b = stk.pop_back(); stk.push_back(a); stk.push_back(b); end
            REDUCE:  if (n < 2) m_unf = 1;
                     else begin void'(stk.pop_back()); void'(stk.pop_back()); stk.push_back(d); busy = (n >= 3); end
            REPLACE: if (n == 0) m_unf = 1; else stk[n-1] = d;
            CLEAR:   begin stk.delete(); m_ovf = 0; m_unf = 0; end
            default: ;
        endcase
        return busy;
    endfunction

    task automatic do_op(input logic [2:0] c, input logic [DW-1:0] d);
        bit busy;
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = c;
        din      = d;
        @(posedge clk);
        busy = model_apply(c, d);
        #1 op_valid = 1'b0;
        $display("op=%0d din=%02h -> model depth=%0d tos=%02h nos=%02h", c, d, stk.size(), m_tos(), m_nos());
        if (busy) begin
            exp_ready = 1'b0;
            @(posedge clk);
            exp_ready = 1'b1;
            #1;
        end
    endtask

    // Per-cycle comparison against the model; NOS is only meaningful once
    // the refill cycle has finished.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("op_ready", op_ready, exp_ready);
                chk("tos", tos, m_tos());
                if (exp_ready) chk("nos", nos, m_nos());
                chk("depth", depth, stk.size());
                chk("empty", empty, stk.size() == 0);
                chk("full", full, stk.size() == DEPTH);
                chk("err_overflow", err_overflow, m_ovf);
                chk("err_underflow", err_underflow, m_unf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        op_valid = 1'b0;
        op_code  = NOP;
        din      = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_tos", tos, 0);
        chk("rst_depth", depth, 0);
        chk("rst_ready", op_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk_en = 1'b1;

        // Three pushes spill the first value into RAM.
        do_op(PUSH, 8'h11); do_op(PUSH, 8'h22); do_op(PUSH, 8'h33);
        chk("t1_tos", tos, 8'h33); chk("t1_nos", nos, 8'h22); chk("t1_depth", depth, 3);
        do_op(POP, 0);
        chk("t2_tos", tos, 8'h22); chk("t2_nos", nos, 8'h11); chk("t2_depth", depth, 2);
        do_op(POP, 0);
        chk("t2b_tos", tos, 8'h11); chk("t2b_nos", nos, 8'h00); chk("t2b_depth", depth, 1);

        // Fill to the top, overflow, then drain.
        do_op(CLEAR, 0);
        for (int i = 0; i < DEPTH; i++) do_op(PUSH, 8'(i));
        chk("t3_full", full, 1); chk("t3_depth", depth, 16);
        do_op(PUSH, 8'hAA);
        chk("t3_ovf", err_overflow, 1); chk("t3_tos", tos, 8'h0F); chk("t3_depth2", depth, 16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_drain", tos, 8'(DEPTH - 1 - i));
            do_op(POP, 0);
        end
        chk("t3_empty", empty, 1);

        // Underflow cases.
        do_op(CLEAR, 0);
        do_op(POP, 0);
        chk("t4_unf", err_underflow, 1); chk("t4_depth", depth, 0);
        do_op(CLEAR, 0);
        chk("t4_unf_clr", err_underflow, 0);
        do_op(PUSH, 8'h42);
        do_op(SWAP, 0);
        chk("t4_swap_unf", err_underflow, 1); chk("t4_tos", tos, 8'h42);
        do_op(REPLACE, 8'h43);
        do_op(REDUCE, 8'h44);

        // Compound ops.
        do_op(CLEAR, 0);
        do_op(DUP, 0);
        do_op(CLEAR, 0);
        do_op(PUSH, 8'h05); do_op(PUSH, 8'h07); do_op(PUSH, 8'h09);
        do_op(SWAP, 0);
        chk("t5_tos", tos, 8'h07); chk("t5_nos", nos, 8'h09);
        do_op(REDUCE, 8'h10);
        chk("t5r_tos", tos, 8'h10); chk("t5r_nos", nos, 8'h05); chk("t5r_depth", depth, 2);
        do_op(REPLACE, 8'h03);
        chk("t5p_tos", tos, 8'h03);
        do_op(NOP, 8'hFF);
        do_op(DUP, 0);
        chk("t5d_nos", nos, 8'h03); chk("t5d_depth", depth, 3);
        do_op(REDUCE, 8'h20);
        do_op(REDUCE, 8'h21);
        chk("t5rr_tos", tos, 8'h21); chk("t5rr_nos", nos, 8'h00);

        // Reset in the middle of a refill.
        do_op(CLEAR, 0);
        for (int i = 1; i <= 4; i++) do_op(PUSH, 8'(i));
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = POP;
        @(posedge clk);
        void'(model_apply(POP, 0));
        #1 op_valid = 1'b0;
        exp_ready = 1'b0;
        #1 reset = 1'b1;
        stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; exp_ready = 1'b1;
        $display("reset asserted during refill");
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("t6_tos", tos, 0); chk("t6_nos", nos, 0); chk("t6_depth", depth, 0); chk("t6_ready", op_ready, 1);
        do_op(PUSH, 8'h05);
        chk("t6p_tos", tos, 8'h05); chk("t6p_depth", depth, 1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_stack_cached.md
Name: data_stack_cached

Overview:
- Parametrised operand stack for the stack datapath, generalising the fixed-width stack/TOS block.
- The top two entries (TOS, NOS) are held in registers; deeper entries spill to an internal synchronous-read RAM.
- Adds a valid/ready op interface, a depth counter, full/empty flags, sticky overflow/underflow errors, and compound ops (DUP, SWAP, REDUCE, REPLACE, CLEAR).
- Sits between the control unit, the ULA result path and the ULA operand registers.

Parameters:
- DATA_WIDTH, 8, width of one stack word.
- DEPTH, 16, maximum number of entries including TOS/NOS; must be >= 4. RAM holds DEPTH-2 words.
- CNT_WIDTH, $clog2(DEPTH+1), localparam, width of the depth counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op_valid  in  1  op request.
- op_ready  out  1  block can accept an op this cycle.
- op_code  in  3  000 NOP, 001 PUSH, 010 POP, 011 DUP, 100 SWAP, 101 REDUCE, 110 REPLACE, 111 CLEAR.
- din  in  DATA_WIDTH  data for PUSH/REDUCE/REPLACE.
- tos  out  DATA_WIDTH  registered top of stack.
- nos  out  DATA_WIDTH  registered next-of-stack.
- depth  out  CNT_WIDTH  entry count, 0..DEPTH.
- empty  out  1  depth==0.
- full  out  1  depth==DEPTH.
- err_overflow  out  1  sticky.
- err_underflow  out  1  sticky.

Behaviour:

Reset:
- Reset is asynchronous and active-high.
- While asserted: tos=0, nos=0, depth=0, err flags=0, FSM=IDLE.
- Outputs then read op_ready=1 (after release), empty=1, full=0.
- Reset asserted mid-REFILL aborts the refill. No RAM write occurs; RAM contents are don't-care.

Handshake:
- An op is accepted on a rising edge with op_valid && op_ready.
- op_ready = (state==IDLE), combinational.
- NOP is accepted and has no effect.

FSM states:
- IDLE: accepts ops.
- REFILL: one cycle, op_ready=0. RAM read data is valid. At the end of REFILL, nos <= ram_rdata and the FSM returns to IDLE.

RAM:
- Entry k (k = depth position 3..DEPTH) lives at index k-3.
- Write is synchronous.
- Read address is registered on the accepting edge; data is valid during the following cycle.

Ops (n = depth before the op):
- PUSH (n<DEPTH): if n>=2 write nos to ram[n-2]. Then nos<=tos, tos<=din, depth<=n+1. 1 cycle.
- DUP (1<=n<DEPTH): as PUSH with din replaced by tos.
- POP (n>=1): tos<=nos, depth<=n-1.
  - If n>=3: issue read of ram[n-3] and enter REFILL. Total 2 cycles.
  - Otherwise: nos<=0.
- SWAP (n>=2): exchange tos/nos. 1 cycle.
- REDUCE (n>=2): tos<=din, depth<=n-1. Used to write back a binary ULA result.
  - If n>=3: refill nos from ram[n-3] via REFILL.
  - Otherwise: nos<=0.
- REPLACE (n>=1): tos<=din. 1 cycle.
- CLEAR: depth<=0, tos<=0, nos<=0, both err flags<=0. 1 cycle.

Errors:
- PUSH/DUP at n==DEPTH sets err_overflow.
- POP/REPLACE/DUP at n==0, or SWAP/REDUCE at n<2, sets err_underflow.
- A faulting op is still accepted (1 cycle) but changes no state other than the flag.
- Flags clear only on reset or CLEAR.

Flags and edge cases:
- full/empty are decoded from the registered depth and update on the same edge as depth.
- Simultaneous overflow and underflow cannot occur (one op per cycle).

Test Plan:
- Reset, PUSH 0x11, 0x22, 0x33 -> tos=0x33, nos=0x22, depth=3, ram[0]=0x11, op_ready stays 1.
- From that state POP -> edge 1: tos=0x22, depth=2, op_ready=0; edge 2: nos=0x11, op_ready=1. POP again -> 1 cycle, tos=0x11, nos=0, depth=1.
- DEPTH=16: push 0..15 -> full=1, depth=16. PUSH 0xAA -> err_overflow=1, tos=15, depth=16. Pop all 16 -> values 15..0 in order, empty=1.
- Empty stack: POP -> err_underflow=1, depth=0. CLEAR -> err_underflow=0. Depth 1: SWAP -> err_underflow=1, tos unchanged.
- Push 5,7,9; SWAP -> tos=7, nos=9. REDUCE din=0x10 -> tos=0x10, nos=5 after REFILL, depth=2. REPLACE din=0x3 -> tos=0x3.
- Push 4 values, issue POP, assert reset during REFILL -> all outputs 0, depth=0, op_ready=1 after release; a following PUSH 0x5 gives tos=0x5, depth=1.
